// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
package instr_mem_loader_pkg;

  localparam int DEPTH_DEF      = 64;
  localparam int AW_DEF         = 6;
  localparam int BYTES_PER_WORD = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t LOAD  = 2'd1;
  localparam state_t WRITE = 2'd2;
  localparam state_t DONE  = 2'd3;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Loader control, byte-stream handshake and instruction-memory write port.
interface instr_mem_loader_if #(
  parameter int AW = 6
);
  logic          start;
  logic [AW:0]   len;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          busy;
  logic          done;
  logic [AW:0]   word_count;

  modport master (
    output start, len, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_waddr, imem_wdata, busy, done, word_count
  );

  modport slave (
    input  start, len, byte_valid, byte_data,
    output byte_ready, imem_we, imem_waddr, imem_wdata, busy, done, word_count
  );
endinterface

// File: rtl/instr_mem_loader_byte_packer.sv
// Assembles consecutive bytes little-endian into a 32-bit word.
module instr_mem_loader_byte_packer
  import instr_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_full
);
  localparam int IW = $clog2(BYTES_PER_WORD);

  logic [IW-1:0] idx;

  // Asserted while the next loaded byte is the last one of the word.
  assign word_full = (idx == IW'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      word <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (load) begin
      idx                    <= idx + IW'(1);
      word[{idx, 3'b000} +: 8] <= din;
    end
  end
endmodule

// File: rtl/instr_mem_loader.sv
// Program loader: byte stream in, 32-bit instruction-memory writes out.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input logic              clk,
  input logic              rst_n,
  instr_mem_loader_if.slave bus
);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t      state;
  logic [AW:0] len_q;
  logic [AW:0] word_count_q;
  logic [AW:0] wc_next;
  logic [AW:0] len_clamped;
  logic        accept;
  logic        word_full;
  logic        pk_clr;
  logic [31:0] pk_word;

  assign accept      = (state == LOAD) && bus.byte_valid;
  assign wc_next     = word_count_q + (AW+1)'(1);
  assign len_clamped = (bus.len > DEPTH_W) ? DEPTH_W : bus.len;
  assign pk_clr      = ((state == IDLE) && bus.start) || (state == WRITE);

  instr_mem_loader_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (pk_clr),
    .load      (accept),
    .din       (bus.byte_data),
    .word      (pk_word),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      len_q        <= '0;
      word_count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            len_q        <= len_clamped;
            word_count_q <= '0;
            state        <= (len_clamped == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (accept && word_full) state <= WRITE;
        end
        WRITE: begin
          word_count_q <= wc_next;
          state        <= (wc_next == len_q) ? DONE : LOAD;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs decode registered state only.
  assign bus.byte_ready = (state == LOAD);
  assign bus.busy       = (state == LOAD) || (state == WRITE);
  assign bus.done       = (state == DONE);
  assign bus.imem_we    = (state == WRITE);
  assign bus.imem_waddr = word_count_q[AW-1:0];
  assign bus.imem_wdata = pk_word;
  assign bus.word_count = word_count_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed, table-driven bench for instr_mem_loader.
module tb_instr_mem_loader;

  typedef struct {
    logic [6:0]  len;
    int unsigned exp_words;
    bit          gaps;
    bit          poke;
    int unsigned base;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_mem_loader_if #(.AW(6)) bus ();

  instr_mem_loader #(.DEPTH(64), .AW(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] prog [0:127];

  int unsigned cyc = 0;
  int unsigned wr_addr[$];
  logic [31:0] wr_data[$];
  int unsigned hs_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned last_we_cyc = 0;
  int unsigned done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.imem_we) begin
        wr_addr.push_back(int'(bus.imem_waddr));
        wr_data.push_back(bus.imem_wdata);
        last_we_cyc = cyc;
      end
      if (bus.byte_valid && bus.byte_ready) hs_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic feed(input int unsigned nbytes, input int unsigned base,
                      input bit gaps, input bit poke);
    int unsigned bi;
    int unsigned guard;
    logic [31:0] w;
    bit acc;
    bi = 0;
    guard = 0;
    while (bi < nbytes && guard < 2000) begin
      w = prog[base + bi / 4];
      bus.byte_data  = w[8 * (bi % 4) +: 8];
      bus.byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.start      = poke && (bi == 3);
      bus.len        = (poke && (bi == 3)) ? 7'd5 : 7'd0;
      if (bus.imem_we) chk("ready_low_in_write", bus.byte_ready, 0);
      acc = bus.byte_valid && bus.byte_ready;
      @(posedge clk); #1;
      if (acc) bi++;
      guard++;
    end
    bus.byte_valid = 1'b0;
    bus.start      = 1'b0;
    bus.len        = '0;
    if (bi < nbytes) chk("feed_timeout", bi, nbytes);
  endtask

  task automatic run_load(input vec_t v);
    int unsigned q0, hs0, d0, sc;
    q0  = wr_addr.size();
    hs0 = hs_cnt;
    d0  = done_cnt;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len   = v.len;
    sc = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.len   = '0;
    chk("busy_after_start", bus.busy, v.exp_words != 0);
    chk("ready_after_start", bus.byte_ready, v.exp_words != 0);
    feed(v.exp_words * 4, v.base, v.gaps, v.poke);
    for (int i = 0; i < 20 && done_cnt == d0; i++) @(posedge clk);
    @(posedge clk); #1;
    chk("done_pulses", done_cnt - d0, 1);
    chk("write_count", wr_addr.size() - q0, v.exp_words);
    if (wr_addr.size() - q0 == v.exp_words) begin
      for (int i = 0; i < int'(v.exp_words); i++) begin
        chk("write_addr", wr_addr[q0 + i], i);
        chk("write_data", wr_data[q0 + i], prog[v.base + i]);
      end
    end
    chk("handshakes", hs_cnt - hs0, 4 * v.exp_words);
    chk("word_count", bus.word_count, v.exp_words);
    if (v.exp_words == 0) chk("done_latency_zero", done_cyc, sc + 1);
    else                  chk("done_after_last_write", done_cyc, last_we_cyc + 1);
    chk("busy_idle", bus.busy, 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_byte_ready", bus.byte_ready, 0);
    chk("rst_imem_we", bus.imem_we, 0);
    chk("rst_imem_waddr", bus.imem_waddr, 0);
    chk("rst_imem_wdata", bus.imem_wdata, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_word_count", bus.word_count, 0);
  endtask

  vec_t vecs [6];

  initial begin
    prog[0] = 32'h0000_7033;
    prog[1] = 32'h0010_0093;
    for (int i = 2; i < 128; i++) prog[i] = {8'(i), 8'hC3, 8'(255 - i), 8'h5A};

    vecs[0] = '{len: 7'd2,   exp_words: 2,  gaps: 1'b0, poke: 1'b0, base: 0};
    vecs[1] = '{len: 7'd2,   exp_words: 2,  gaps: 1'b1, poke: 1'b0, base: 0};
    vecs[2] = '{len: 7'd0,   exp_words: 0,  gaps: 1'b0, poke: 1'b0, base: 0};
    vecs[3] = '{len: 7'd100, exp_words: 64, gaps: 1'b0, poke: 1'b0, base: 0};
    vecs[4] = '{len: 7'd2,   exp_words: 2,  gaps: 1'b0, poke: 1'b1, base: 0};
    vecs[5] = '{len: 7'd3,   exp_words: 3,  gaps: 1'b1, poke: 1'b0, base: 7};

    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.len        = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) run_load(vecs[v]);

    // Abort a two-word load after six bytes, then reload one fresh word.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len   = 7'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.len   = '0;
    feed(6, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_load('{len: 7'd1, exp_words: 1, gaps: 1'b0, poke: 1'b0, base: 9});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
